// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM model: decodes controller commands, tracks open rows per bank
// and runs burst reads/writes against an internal word array.
module sdram_cmd_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12,
   parameter int COL_W   = 8,
   parameter int ROW_USE = 2
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                MEM_CKE,
   input  logic                MEM_CSn,
   input  logic                MEM_RASn,
   input  logic                MEM_CASn,
   input  logic                MEM_WEn,
   input  logic [1:0]          MEM_BA,
   input  logic [ADDR_W-1:0]   MEM_ADDR,
   input  logic [DATA_W-1:0]   MEM_WDATA,
   input  logic [DATA_W/8-1:0] MEM_DQM,
   output logic [DATA_W-1:0]   MEM_RDATA,
   output logic                MEM_RVALID,
   output logic                PROTO_ERR,
   output logic [15:0]         REF_CNT
);

   localparam int LANES  = DATA_W / 8;
   localparam int MEM_AW = 2 + ROW_USE + COL_W;
   localparam int DEPTH  = 1 << MEM_AW;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   state_t               state_reg, state_next;
   logic [3:0]           burst_idx_reg, idx_next;
   logic [1:0]           burst_bank_reg;
   logic [ROW_USE-1:0]   burst_row_reg;
   logic [COL_W-1:0]     burst_col_reg;
   logic [3:0]           bank_open_reg;
   logic [ROW_USE-1:0]   bank_row_reg [4];
   logic [1:0]           bl_log_reg;
   logic [1:0]           cl_reg;
   logic [1:0]           pipe_valid_reg;
   logic [MEM_AW-1:0]    pipe_addr_reg [2];
   logic [DATA_W-1:0]    mem [DEPTH];

   logic [3:0]           cmd;
   logic                 is_act, is_rd, is_wr, is_bt, is_pre, is_ref, is_lmr;
   logic                 bank_hit, rd_ok, wr_ok, any_open, burst_last, err;
   logic [3:0]           bl_len;
   logic [MEM_AW-1:0]    cmd_addr, burst_addr;
   logic                 req_valid, wr_en, start, flush, sel_valid;
   logic [MEM_AW-1:0]    req_addr, wr_addr, sel_addr;
   logic [DATA_W-1:0]    lane_keep;
   logic                 unused_addr;

   // Column for burst word i: wraps inside the BL-aligned block of 2^b columns.
   function automatic logic [COL_W-1:0] wrap_col(input logic [COL_W-1:0] c,
                                                 input logic [3:0] i,
                                                 input logic [1:0] b);
      logic [COL_W-1:0] m;
      m = ~({COL_W{1'b1}} << b);
      return (c & ~m) | ((c + COL_W'(i)) & m);
   endfunction

   assign cmd    = {MEM_CSn, MEM_RASn, MEM_CASn, MEM_WEn};
   assign is_act = (cmd == 4'b0011);
   assign is_rd  = (cmd == 4'b0101);
   assign is_wr  = (cmd == 4'b0100);
   assign is_bt  = (cmd == 4'b0110);
   assign is_pre = (cmd == 4'b0010);
   assign is_ref = (cmd == 4'b0001);
   assign is_lmr = (cmd == 4'b0000);

   assign bank_hit   = bank_open_reg[MEM_BA];
   assign rd_ok      = is_rd && bank_hit;
   assign wr_ok      = is_wr && bank_hit;
   assign any_open   = |bank_open_reg;
   assign bl_len     = 4'd1 << bl_log_reg;
   assign burst_last = (burst_idx_reg == bl_len - 4'd1);
   assign cmd_addr   = {MEM_BA, bank_row_reg[MEM_BA], MEM_ADDR[COL_W-1:0]};
   assign burst_addr = {burst_bank_reg, burst_row_reg,
                        wrap_col(burst_col_reg, burst_idx_reg, bl_log_reg)};
   assign unused_addr = ^MEM_ADDR;

   assign err = (is_act && bank_hit)
             || (is_lmr && (any_open || (state_reg != IDLE)))
             || (is_ref && any_open)
             || ((is_rd || is_wr) && !bank_hit);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_keep[gi*8 +: 8] = {8{~MEM_DQM[gi]}};
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = burst_idx_reg;
      req_valid  = 1'b0;
      req_addr   = burst_addr;
      wr_en      = 1'b0;
      wr_addr    = burst_addr;
      start      = 1'b0;
      flush      = 1'b0;
      if (rd_ok || wr_ok) begin
         // A new READ/WRITE always wins over whatever burst is running.
         start    = 1'b1;
         idx_next = (bl_len == 4'd1) ? 4'd0 : 4'd1;
         if (rd_ok) begin
            req_valid  = 1'b1;
            req_addr   = cmd_addr;
            state_next = (bl_len == 4'd1) ? IDLE : RD_BURST;
         end else begin
            wr_en      = 1'b1;
            wr_addr    = cmd_addr;
            state_next = (bl_len == 4'd1) ? IDLE : WR_BURST;
         end
      end else if (is_bt || is_pre) begin
         state_next = IDLE;
         idx_next   = 4'd0;
         flush      = 1'b1;
      end else begin
         case (state_reg)
            RD_BURST: begin
               req_valid = 1'b1;
               idx_next  = burst_idx_reg + 4'd1;
               if (burst_last) begin
                  state_next = IDLE;
                  idx_next   = 4'd0;
               end
            end
            WR_BURST: begin
               wr_en    = 1'b1;
               idx_next = burst_idx_reg + 4'd1;
               if (burst_last) begin
                  state_next = IDLE;
                  idx_next   = 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // CAS latency: CL=1 loads the request directly, CL=2/3 take it from the delay pipe.
   always_comb begin
      sel_valid = req_valid;
      sel_addr  = req_addr;
      if (cl_reg == 2'd2) begin
         sel_valid = pipe_valid_reg[0];
         sel_addr  = pipe_addr_reg[0];
      end else if (cl_reg == 2'd3) begin
         sel_valid = pipe_valid_reg[1];
         sel_addr  = pipe_addr_reg[1];
      end
      if (flush) sel_valid = 1'b0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg      <= IDLE;
         burst_idx_reg  <= 4'd0;
         burst_bank_reg <= 2'd0;
         burst_row_reg  <= '0;
         burst_col_reg  <= '0;
         bank_open_reg  <= 4'd0;
         for (int i = 0; i < 4; i++) bank_row_reg[i] <= '0;
         bl_log_reg     <= 2'd3;
         cl_reg         <= 2'd1;
         pipe_valid_reg <= 2'd0;
         for (int i = 0; i < 2; i++) pipe_addr_reg[i] <= '0;
         MEM_RDATA      <= '0;
         MEM_RVALID     <= 1'b0;
         PROTO_ERR      <= 1'b0;
         REF_CNT        <= 16'd0;
      end else if (MEM_CKE) begin
         state_reg     <= state_next;
         burst_idx_reg <= idx_next;
         if (start) begin
            burst_bank_reg <= MEM_BA;
            burst_row_reg  <= bank_row_reg[MEM_BA];
            burst_col_reg  <= MEM_ADDR[COL_W-1:0];
         end
         if (is_act) begin
            bank_open_reg[MEM_BA] <= 1'b1;
            bank_row_reg[MEM_BA]  <= MEM_ADDR[ROW_USE-1:0];
         end else if (is_pre) begin
            if (MEM_ADDR[10]) bank_open_reg <= 4'd0;
            else bank_open_reg[MEM_BA] <= 1'b0;
         end
         if (is_lmr) begin
            bl_log_reg <= (MEM_ADDR[2:0] <= 3'd3) ? MEM_ADDR[1:0] : 2'd3;
            case (MEM_ADDR[6:4])
               3'd2:    cl_reg <= 2'd2;
               3'd3:    cl_reg <= 2'd3;
               default: cl_reg <= 2'd1;
            endcase
         end
         if (is_ref) REF_CNT <= REF_CNT + 16'd1;
         PROTO_ERR         <= err;
         pipe_valid_reg[0] <= req_valid && !flush;
         pipe_valid_reg[1] <= pipe_valid_reg[0] && !flush;
         pipe_addr_reg[0]  <= req_addr;
         pipe_addr_reg[1]  <= pipe_addr_reg[0];
         MEM_RVALID        <= sel_valid;
         if (sel_valid) MEM_RDATA <= mem[sel_addr] & lane_keep;
      end
   end

   always_ff @(posedge HCLK) begin
      if (MEM_CKE && wr_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (!MEM_DQM[l]) mem[wr_addr][l*8 +: 8] <= MEM_WDATA[l*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: each task drives one scenario and
// compares outputs shortly after the active edge against hand-computed values.
module tb_sdram_cmd_responder;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_BT  = 4'b0110;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   logic        clk, rst_n, cke;
   logic        csn, rasn, casn, wen;
   logic [1:0]  ba;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [3:0]  dqm;
   logic [31:0] rdata;
   logic        rvalid, perr;
   logic [15:0] ref_cnt;

   int tests;
   int errors;

   sdram_cmd_responder dut (
      .HCLK(clk), .HRESETn(rst_n), .MEM_CKE(cke),
      .MEM_CSn(csn), .MEM_RASn(rasn), .MEM_CASn(casn), .MEM_WEn(wen),
      .MEM_BA(ba), .MEM_ADDR(addr), .MEM_WDATA(wdata), .MEM_DQM(dqm),
      .MEM_RDATA(rdata), .MEM_RVALID(rvalid), .PROTO_ERR(perr), .REF_CNT(ref_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one command for one edge, then fall back to NOP.
   task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      {csn, rasn, casn, wen} = c;
      ba = b; addr = a; wdata = d; dqm = m;
      @(posedge clk); #1;
      {csn, rasn, casn, wen} = C_NOP;
      dqm = 4'h0;
   endtask

   task automatic nop();
      issue(C_NOP, 2'd0, 12'h000, 32'h0, 4'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr); end
      tests++; if (ref_cnt !== 16'h0) begin errors++; $display("FAIL reset_refcnt: got %h expected 0000", ref_cnt); end
      rst_n = 1'b1;
      nop();
   endtask

   task automatic test_basic_write();
      issue(C_ACT, 2'd0, 12'h001, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL basic_act_perr: got %b expected 0", perr); end
      issue(C_WR, 2'd0, 12'h005, 32'h0000_0007, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL basic_wr_perr: got %b expected 0", perr); end
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL basic_bt_perr: got %b expected 0", perr); end
      issue(C_RD, 2'd0, 12'h005, 32'h0, 4'h0);
      tests++; if (rvalid !== 1'b1 || rdata !== 32'h7) begin errors++; $display("FAIL basic_readback: got v=%b d=%h expected v=1 d=00000007", rvalid, rdata); end
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_bt_stop: got %b expected 0", rvalid); end
      nop();
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", rvalid); end
   endtask

   task automatic test_read_wrap();
      logic [31:0] exp8 [8];
      exp8 = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd8, 32'd9, 32'd10};
      issue(C_WR, 2'd0, 12'h008, 32'd8, 4'h0);
      for (int i = 9; i <= 15; i++) issue(C_NOP, 2'd0, 12'h000, 32'(i), 4'h0);
      issue(C_RD, 2'd0, 12'h00B, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (rvalid !== 1'b1 || rdata !== exp8[i]) begin
            errors++; $display("FAIL wrap_word%0d: got v=%b d=%h expected v=1 d=%h", i, rvalid, rdata, exp8[i]);
         end
         if (i < 7) nop();
      end
      nop();
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wrap_end: got %b expected 0", rvalid); end
   endtask

   task automatic test_cl3();
      logic        expv [7];
      logic [31:0] expd [7];
      expv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      expd = '{32'h0, 32'h0, 32'h102, 32'h103, 32'h100, 32'h101, 32'h0};
      issue(C_PRE, 2'd0, 12'h400, 32'h0, 4'h0);
      issue(C_LMR, 2'd0, 12'h032, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL cl3_lmr_perr: got %b expected 0", perr); end
      issue(C_ACT, 2'd0, 12'h001, 32'h0, 4'h0);
      issue(C_WR, 2'd0, 12'h000, 32'h100, 4'h0);
      for (int i = 1; i < 4; i++) issue(C_NOP, 2'd0, 12'h000, 32'h100 + 32'(i), 4'h0);
      issue(C_RD, 2'd0, 12'h002, 32'h0, 4'h0);
      for (int j = 0; j < 7; j++) begin
         tests++;
         if (rvalid !== expv[j] || (expv[j] && rdata !== expd[j])) begin
            errors++; $display("FAIL cl3_cycle%0d: got v=%b d=%h expected v=%b d=%h", j, rvalid, rdata, expv[j], expd[j]);
         end
         if (j < 6) nop();
      end
      issue(C_PRE, 2'd0, 12'h400, 32'h0, 4'h0);
      issue(C_LMR, 2'd0, 12'h003, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL cl1_restore_perr: got %b expected 0", perr); end
   endtask

   task automatic test_errors();
      issue(C_RD, 2'd2, 12'h000, 32'h0, 4'h0);
      tests++; if (perr !== 1'b1) begin errors++; $display("FAIL err_rd_closed: got %b expected 1", perr); end
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL err_rd_closed_rvalid: got %b expected 0", rvalid); end
      nop();
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", perr); end
      issue(C_ACT, 2'd1, 12'h000, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL err_act_b1: got %b expected 0", perr); end
      issue(C_REF, 2'd0, 12'h000, 32'h0, 4'h0);
      tests++; if (perr !== 1'b1 || ref_cnt !== 16'd1) begin errors++; $display("FAIL err_ref_open: got perr=%b cnt=%0d expected perr=1 cnt=1", perr, ref_cnt); end
      issue(C_ACT, 2'd1, 12'h000, 32'h0, 4'h0);
      tests++; if (perr !== 1'b1) begin errors++; $display("FAIL err_act_twice: got %b expected 1", perr); end
      issue(C_LMR, 2'd0, 12'h003, 32'h0, 4'h0);
      tests++; if (perr !== 1'b1) begin errors++; $display("FAIL err_lmr_open: got %b expected 1", perr); end
      issue(C_PRE, 2'd0, 12'h400, 32'h0, 4'h0);
      tests++; if (perr !== 1'b0) begin errors++; $display("FAIL err_pre_all: got %b expected 0", perr); end
   endtask

   task automatic test_precharge_mid();
      issue(C_ACT, 2'd0, 12'h001, 32'h0, 4'h0);
      issue(C_RD, 2'd0, 12'h008, 32'h0, 4'h0);
      tests++; if (rvalid !== 1'b1 || rdata !== 32'd8) begin errors++; $display("FAIL pre_word0: got v=%b d=%h expected v=1 d=00000008", rvalid, rdata); end
      nop();
      tests++; if (rdata !== 32'd9) begin errors++; $display("FAIL pre_word1: got %h expected 00000009", rdata); end
      nop();
      tests++; if (rdata !== 32'd10) begin errors++; $display("FAIL pre_word2: got %h expected 0000000a", rdata); end
      issue(C_PRE, 2'd0, 12'h400, 32'h0, 4'h0);
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL pre_stop: got %b expected 0", rvalid); end
      nop();
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL pre_stays_idle: got %b expected 0", rvalid); end
      issue(C_RD, 2'd0, 12'h008, 32'h0, 4'h0);
      tests++; if (perr !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL pre_banks_closed: got perr=%b v=%b expected perr=1 v=0", perr, rvalid); end
   endtask

   task automatic test_reset_mid();
      issue(C_ACT, 2'd0, 12'h001, 32'h0, 4'h0);
      issue(C_RD, 2'd0, 12'h008, 32'h0, 4'h0);
      nop();
      tests++; if (rvalid !== 1'b1 || rdata !== 32'd9) begin errors++; $display("FAIL rst_mid_pre: got v=%b d=%h expected v=1 d=00000009", rvalid, rdata); end
      rst_n = 1'b0;
      #1;
      tests++; if (rdata !== 32'h0 || rvalid !== 1'b0 || perr !== 1'b0 || ref_cnt !== 16'h0) begin
         errors++; $display("FAIL rst_mid_async: got d=%h v=%b perr=%b cnt=%h expected all 0", rdata, rvalid, perr, ref_cnt);
      end
      @(posedge clk); #1;
      tests++; if (rdata !== 32'h0 || rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got d=%h v=%b expected 0", rdata, rvalid); end
      rst_n = 1'b1;
      nop();
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_aborted: got %b expected 0", rvalid); end
   endtask

   task automatic test_dqm();
      issue(C_ACT, 2'd3, 12'h002, 32'h0, 4'h0);
      issue(C_WR, 2'd3, 12'h020, 32'h1122_3344, 4'h0);
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      issue(C_WR, 2'd3, 12'h020, 32'hAABB_CCDD, 4'b0101);
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      issue(C_RD, 2'd3, 12'h020, 32'h0, 4'h0);
      tests++; if (rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL dqm_write: got %h expected aa22cc44", rdata); end
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      issue(C_RD, 2'd3, 12'h020, 32'h0, 4'b0011);
      tests++; if (rdata !== 32'hAA22_0000) begin errors++; $display("FAIL dqm_read: got %h expected aa220000", rdata); end
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
   endtask

   task automatic test_cke();
      issue(C_RD, 2'd3, 12'h020, 32'h0, 4'h0);
      cke = 1'b0;
      nop();
      nop();
      tests++; if (rvalid !== 1'b1 || rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL cke_freeze_burst: got v=%b d=%h expected v=1 d=aa22cc44", rvalid, rdata); end
      cke = 1'b1;
      issue(C_BT, 2'd0, 12'h000, 32'h0, 4'h0);
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL cke_bt: got %b expected 0", rvalid); end
      cke = 1'b0;
      issue(C_RD, 2'd3, 12'h020, 32'h0, 4'h0);
      issue(C_REF, 2'd0, 12'h000, 32'h0, 4'h0);
      cke = 1'b1;
      nop();
      tests++; if (rvalid !== 1'b0) begin errors++; $display("FAIL cke_read_ignored: got %b expected 0", rvalid); end
      tests++; if (ref_cnt !== 16'h0 || perr !== 1'b0) begin errors++; $display("FAIL cke_ref_ignored: got cnt=%0d perr=%b expected cnt=0 perr=0", ref_cnt, perr); end
   endtask

   initial begin
      tests = 0;
      errors = 0;
      cke = 1'b1;
      rst_n = 1'b0;
      {csn, rasn, casn, wen} = C_NOP;
      ba = 2'd0; addr = 12'h0; wdata = 32'h0; dqm = 4'h0;
      test_reset();
      test_basic_write();
      test_read_wrap();
      test_cl3();
      test_errors();
      test_precharge_mid();
      test_reset_mid();
      test_dqm();
      test_cke();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
